// File: rtl/rx.sv
// Odd-parity UART receiver: 8 data bits LSB first, 1 parity bit, 1 stop bit.
// Frames are sampled at bit mid-points, timed from the synchronized start edge.
module rx #(
  parameter int BIT_PERIOD  = 5210,
  parameter int HALF_PERIOD = BIT_PERIOD / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] dout,
  output logic       data_strobe,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    BITS      = 3'd2,
    PAR       = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  localparam logic [12:0] BIT_LAST  = 13'(BIT_PERIOD - 1);
  localparam logic [12:0] HALF_LAST = 13'(HALF_PERIOD - 1);

  // High when data plus parity bit do not hold an odd number of ones.
  function automatic logic oddParityBad(input logic [7:0] data, input logic parBit);
    return ~(^data ^ parBit);
  endfunction

  state_t      state_r, nextState_s;
  logic        sync1_r, sync2_r, rx_s;
  logic [12:0] timer_r;
  logic [2:0]  bitCnt_r;
  logic [7:0]  shift_r;
  logic        parBit_r;
  logic        timerWrap_s, timerClr_s;
  logic        startOk_s, shiftEn_s, parEn_s, stopEn_s;

  assign rx_s        = sync2_r;
  assign timerWrap_s = (timer_r == BIT_LAST);

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx_in;
      sync2_r <= sync1_r;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= nextState_s;
  end

  // Next-state and per-cycle sampling controls.
  always_comb begin
    nextState_s = state_r;
    timerClr_s  = 1'b0;
    startOk_s   = 1'b0;
    shiftEn_s   = 1'b0;
    parEn_s     = 1'b0;
    stopEn_s    = 1'b0;
    case (state_r)
      IDLE: begin
        timerClr_s = 1'b1;
        if (!rx_s) nextState_s = START;
        else       nextState_s = IDLE;
      end
      START: begin
        // Mid-start-bit check rejects short low glitches.
        if (timer_r == HALF_LAST) begin
          timerClr_s = 1'b1;
          if (rx_s) begin
            nextState_s = IDLE;
          end else begin
            nextState_s = BITS;
            startOk_s   = 1'b1;
          end
        end else begin
          nextState_s = START;
        end
      end
      BITS: begin
        if (timerWrap_s) begin
          shiftEn_s = 1'b1;
          if (bitCnt_r == 3'd7) nextState_s = PAR;
          else                  nextState_s = BITS;
        end else begin
          nextState_s = BITS;
        end
      end
      PAR: begin
        if (timerWrap_s) begin
          parEn_s     = 1'b1;
          nextState_s = STOP;
        end else begin
          nextState_s = PAR;
        end
      end
      STOP: begin
        if (timerWrap_s) begin
          stopEn_s = 1'b1;
          if (rx_s) nextState_s = IDLE;
          else      nextState_s = WAIT_HIGH;
        end else begin
          nextState_s = STOP;
        end
      end
      WAIT_HIGH: begin
        // A held-low break must not look like a new start bit.
        timerClr_s = 1'b1;
        if (rx_s) nextState_s = IDLE;
        else      nextState_s = WAIT_HIGH;
      end
      default: begin
        timerClr_s  = 1'b1;
        nextState_s = IDLE;
      end
    endcase
  end

  // Baud timer, bit counter, shift register and registered frame results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r       <= 13'd0;
      bitCnt_r      <= 3'd0;
      shift_r       <= 8'h00;
      parBit_r      <= 1'b0;
      dout          <= 8'h00;
      data_strobe   <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      data_strobe <= 1'b0;
      busy        <= (nextState_s != IDLE);
      if (timerClr_s || timerWrap_s) timer_r <= 13'd0;
      else                           timer_r <= timer_r + 13'd1;
      if (startOk_s)      bitCnt_r <= 3'd0;
      else if (shiftEn_s) bitCnt_r <= bitCnt_r + 3'd1;
      if (shiftEn_s) shift_r  <= {rx_s, shift_r[7:1]};
      if (parEn_s)   parBit_r <= rx_s;
      if (stopEn_s) begin
        parity_error  <= oddParityBad(shift_r, parBit_r);
        framing_error <= ~rx_s;
        if (rx_s) begin
          dout        <= shift_r;
          data_strobe <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx.sv
// Directed bench for rx with a shortened bit period (16 cycles, half 8) so
// every scenario fits in a short run; expected values are hand-derived.
module tb_rx;

  localparam int BP   = 16;
  localparam int HP   = 8;
  // Drive of start bit (at a negedge) to strobe visible: 2 sync + 1 + HP + 10*BP.
  localparam int STROBE_LAT = 3 + HP + 10 * BP;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [7:0] dout;
  logic       data_strobe;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int strobeCnt = 0;
  int multiPulse = 0;
  int busyAtStrobe = 0;
  int busyDrops;
  int frameC0;
  int b2bStart;
  logic prevStrobe = 1'b0;
  logic [7:0] dataLog[$];
  int cycLog[$];

  rx #(.BIT_PERIOD(BP), .HALF_PERIOD(HP)) dut (
    .clk(clk),
    .rst(rst),
    .rx_in(rx_in),
    .dout(dout),
    .data_strobe(data_strobe),
    .parity_error(parity_error),
    .framing_error(framing_error),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe observer: logs each pulse and flags wide pulses or busy during strobe.
  always @(negedge clk) begin
    if (data_strobe) begin
      strobeCnt <= strobeCnt + 1;
      dataLog.push_back(dout);
      cycLog.push_back(cyc);
      if (prevStrobe) multiPulse <= multiPulse + 1;
      if (busy) busyAtStrobe <= busyAtStrobe + 1;
    end
    prevStrobe <= data_strobe;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveBit(input logic v);
    rx_in = v;
    repeat (BP) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic par, input logic stp);
    frameC0 = cyc;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(d[i]);
    driveBit(par);
    driveBit(stp);
  endtask

  initial begin
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dout", {24'd0, dout}, 32'h00);
    chk("reset_strobe", {31'd0, data_strobe}, 32'd0);
    chk("reset_perr", {31'd0, parity_error}, 32'd0);
    chk("reset_ferr", {31'd0, framing_error}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Good frame 0x41, correct odd parity 1.
    sendFrame(8'h41, 1'b1, 1'b1);
    chk("good_count", strobeCnt, 32'd1);
    chk("good_latency", cycLog[0] - frameC0, STROBE_LAT);
    chk("good_logdata", {24'd0, dataLog[0]}, 32'h41);
    chk("good_dout", {24'd0, dout}, 32'h41);
    chk("good_perr", {31'd0, parity_error}, 32'd0);
    chk("good_ferr", {31'd0, framing_error}, 32'd0);
    chk("good_busy", {31'd0, busy}, 32'd0);

    // 0xA5 has four ones, so parity 0 is wrong.
    sendFrame(8'hA5, 1'b0, 1'b1);
    chk("perr_count", strobeCnt, 32'd2);
    chk("perr_dout", {24'd0, dout}, 32'hA5);
    chk("perr_perr", {31'd0, parity_error}, 32'd1);
    chk("perr_ferr", {31'd0, framing_error}, 32'd0);

    sendFrame(8'h00, 1'b1, 1'b1);
    chk("pclr_count", strobeCnt, 32'd3);
    chk("pclr_dout", {24'd0, dout}, 32'h00);
    chk("pclr_perr", {31'd0, parity_error}, 32'd0);

    // Framing error followed by a long break.
    sendFrame(8'h3C, 1'b1, 1'b0);
    busyDrops = 0;
    repeat (20000) begin
      @(negedge clk);
      if (!busy) busyDrops++;
    end
    chk("ferr_busy_held", busyDrops, 32'd0);
    chk("ferr_count", strobeCnt, 32'd3);
    chk("ferr_dout", {24'd0, dout}, 32'h00);
    chk("ferr_ferr", {31'd0, framing_error}, 32'd1);
    chk("ferr_perr", {31'd0, parity_error}, 32'd0);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("ferr_busy_until_high", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    chk("ferr_busy_released", {31'd0, busy}, 32'd0);
    repeat (10) @(negedge clk);

    // Low glitch shorter than half a bit.
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    chk("glitch_busy_rise", {31'd0, busy}, 32'd1);
    repeat (HP + 4) @(negedge clk);
    chk("glitch_busy_fall", {31'd0, busy}, 32'd0);
    chk("glitch_count", strobeCnt, 32'd3);
    chk("glitch_dout", {24'd0, dout}, 32'h00);
    chk("glitch_ferr", {31'd0, framing_error}, 32'd1);
    chk("glitch_perr", {31'd0, parity_error}, 32'd0);
    repeat (10) @(negedge clk);

    // Reset in the middle of data bit 4 of a 0x7E frame.
    driveBit(1'b0);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b1);
    driveBit(1'b1);
    rx_in = 1'b1;
    repeat (BP / 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_ferr", {31'd0, framing_error}, 32'd0);
    chk("mrst_perr", {31'd0, parity_error}, 32'd0);
    chk("mrst_dout", {24'd0, dout}, 32'h00);
    chk("mrst_strobe", {31'd0, data_strobe}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    sendFrame(8'h7E, 1'b1, 1'b1);
    chk("post_rst_count", strobeCnt, 32'd4);
    chk("post_rst_latency", cycLog[3] - frameC0, STROBE_LAT);
    chk("post_rst_dout", {24'd0, dout}, 32'h7E);
    chk("post_rst_perr", {31'd0, parity_error}, 32'd0);
    chk("post_rst_ferr", {31'd0, framing_error}, 32'd0);

    // Back-to-back frames with no idle gap.
    b2bStart = cyc;
    sendFrame(8'h00, 1'b1, 1'b1);
    sendFrame(8'hFF, 1'b1, 1'b1);
    sendFrame(8'h55, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("b2b_count", strobeCnt, 32'd7);
    chk("b2b_data0", {24'd0, dataLog[4]}, 32'h00);
    chk("b2b_data1", {24'd0, dataLog[5]}, 32'hFF);
    chk("b2b_data2", {24'd0, dataLog[6]}, 32'h55);
    chk("b2b_first_latency", cycLog[4] - b2bStart, STROBE_LAT);
    chk("b2b_gap01", cycLog[5] - cycLog[4], 32'(11 * BP));
    chk("b2b_gap12", cycLog[6] - cycLog[5], 32'(11 * BP));
    chk("b2b_perr", {31'd0, parity_error}, 32'd0);
    chk("b2b_ferr", {31'd0, framing_error}, 32'd0);

    chk("strobe_single_cycle", multiPulse, 32'd0);
    chk("busy_low_at_strobe", busyAtStrobe, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx.md
# rx

Asynchronous serial receiver, the receive-side counterpart of the team's odd-parity UART transmitter. It samples the serial line `rx_in` and reassembles each frame: 1 start bit (0), 8 data bits LSB first, 1 odd-parity bit, 1 stop bit (1). Each received byte is presented on `dout` with a one-cycle `data_strobe`, along with per-frame parity and framing status. It sits between the board's UART RX pin and any byte-consuming logic.

## Interface
- `BIT_PERIOD`, 5210: clock cycles per serial bit. The timer counts 0..5209.
- `HALF_PERIOD`, `BIT_PERIOD/2` (2605): cycles from start-edge detection to the start-bit mid-point sample.
- `clk` in 1: single system clock; all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `rx_in` in 1: serial line, idle high, asynchronous to `clk`.
- `dout` out 8: last received byte.
- `data_strobe` out 1: one-cycle pulse when `dout` is updated with a good-framed byte.
- `parity_error` out 1: last completed frame had bad odd parity.
- `framing_error` out 1: last completed frame had stop bit = 0.
- `busy` out 1: high while a frame is in progress, i.e. in any state other than IDLE.

## Operation
- **Synchronizer.** `rx_in` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized signal `rx_s`.
- **Timer.** 13-bit baud timer, cleared in IDLE, wraps at `BIT_PERIOD-1`.
- **Bit counter.** 3-bit counter, indexes data bits 0..7.
- **Shift register.** 8 bits; each sampled data bit enters at the MSB and shifts right, so bit 0 ends at LSB.
- **FSM states:** IDLE, START, BITS, PAR, STOP, WAIT_HIGH.
  - IDLE: `busy`=0. If `rx_s`==0, clear the timer and go to START.
  - START: at timer == `HALF_PERIOD-1`, sample `rx_s`. If 1, the low pulse was a glitch: return to IDLE with no output change. If 0, restart the timer, clear the bit counter, and go to BITS.
  - BITS: at each timer wrap, sample one data bit. After bit 7, go to PAR.
  - PAR: at timer wrap, sample the parity bit and go to STOP.
  - STOP: at timer wrap, sample the stop bit.
    - Stop = 1: load `dout`; pulse `data_strobe`; set `parity_error` = (XOR of data bits and parity bit) == 0; clear `framing_error`; go to IDLE.
    - Stop = 0: set `framing_error`=1; set `parity_error` as above; leave `dout` unchanged; no strobe; go to WAIT_HIGH.
  - WAIT_HIGH: `busy`=1. Go to IDLE once `rx_s`==1. This prevents a break condition from re-triggering frames.
- **Error flags.** `parity_error` and `framing_error` are updated only at a frame's stop sample. They hold until the next frame's stop sample.
- **Reset.** Reset mid-frame abandons the frame immediately.
- **Reset values:** state IDLE, `dout`=0x00, `data_strobe`=0, `parity_error`=0, `framing_error`=0, `busy`=0, timer=0, bit counter=0, synchronizer flops=1.

## Timing
- Let T0 be the first cycle IDLE sees `rx_s`==0. A pin falling edge reaches `rx_s` 2 cycles after it is registered.
- **Sample points:**
  - Start bit: T0+`HALF_PERIOD`.
  - Data bit i (i = 0..7): T0+`HALF_PERIOD`+(i+1)·`BIT_PERIOD`.
  - Parity bit: +9·`BIT_PERIOD`.
  - Stop bit: +10·`BIT_PERIOD`.
- `dout`, `data_strobe` and the error flags are registered. They become visible the cycle after the stop sample. `data_strobe` is high for exactly 1 cycle.
- `busy` rises the cycle after T0 and falls in the same cycle `data_strobe` rises, for a good frame. On a framing error, `busy` falls the cycle after WAIT_HIGH sees `rx_s`==1.
- **Back-to-back frames.** The FSM is back in IDLE during the strobe cycle. A start bit immediately following the stop bit is therefore detected with no lost frame. Minimum stop-bit length is 1/2 bit.
- No backpressure: the consumer must capture `dout` on `data_strobe`. `dout` holds until the next good frame.

## Test plan
- **Good frame.** Drive 0x41 with parity 1 and stop 1 at `BIT_PERIOD` per bit. Expect `dout`=0x41, a single-cycle `data_strobe` at T0+2605+52100+1, `parity_error`=0, `framing_error`=0, `busy` low after.
- **Parity error.** Drive 0xA5 with parity 0 (wrong). Expect `dout`=0xA5, `data_strobe` pulse, `parity_error`=1, `framing_error`=0. Then send 0x00 with parity 1: expect `parity_error` cleared to 0.
- **Framing error.** Drive 0x3C with stop bit 0, then hold the line low for 20000 cycles, then release it high. Expect no `data_strobe`, `dout` unchanged, `framing_error`=1, `busy` high until the line returns high, and no new frame started during the low period.
- **Glitch.** Drive a 1000-cycle low pulse on an idle line. Expect return to IDLE at the start-bit sample, no `data_strobe`, all outputs unchanged.
- **Reset mid-frame.** Assert `rst` (asynchronously) during data bit 4 of a frame. Expect all outputs to go to their reset values immediately. A subsequent full 0x7E frame is received correctly, with `parity_error`=0.
- **Back-to-back.** Send 0x00, 0xFF, 0x55 with no idle gap between them. Expect three strobes with `dout` = 0x00, 0xFF, 0x55 in order, spaced 11·`BIT_PERIOD` apart, and no errors.
